// File: rtl/fft_frame_streamer_if.sv
// rtl/fft_frame_streamer_if.sv - sample RAM read port and FFT Avalon-ST sink bundle
interface fft_frame_streamer_if #(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 8,
    parameter int CH_BITS   = 2
);
    logic                 rd_en;
    logic [CH_BITS-1:0]   rd_ch;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [DATA_BITS-1:0] rd_data;
    logic                 sink_valid;
    logic                 sink_ready;
    logic                 sink_sop;
    logic                 sink_eop;
    logic [DATA_BITS-1:0] sink_real;
    logic [DATA_BITS-1:0] sink_imag;
    logic [1:0]           sink_error;
    logic [CH_BITS-1:0]   frame_ch;

    modport master (
        output rd_en, rd_ch, rd_addr,
        input  rd_data,
        output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error, frame_ch,
        input  sink_ready
    );

    modport slave (
        input  rd_en, rd_ch, rd_addr,
        output rd_data,
        input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error, frame_ch,
        output sink_ready
    );
endinterface

// File: rtl/fft_frame_streamer.sv
// rtl/fft_frame_streamer.sv - streams NUM_CH banked RAM frames into the FFT sink via a 2-entry skid buffer
// Optional OFFSET_BINARY_IN_EN: treat rd_data as offset-binary and convert to two's complement.
module fft_frame_streamer #(
    parameter int FRAME_LEN = 512,
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 8,
    parameter int NUM_CH    = 4,
    parameter int CH_BITS   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    fft_frame_streamer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    // Buffer entry layout: {channel, eop, sop, sample}
    localparam int TW = CH_BITS + 2;
    localparam int EW = TW + DATA_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_LEN - 1);
    localparam logic [CH_BITS-1:0]   LAST_CH   = CH_BITS'(NUM_CH - 1);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [CH_BITS-1:0]   ch_q, ch_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 inflight_q, inflight_d;
    logic [TW-1:0]        tag_q, tag_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [EW-1:0]        ent0_q, ent0_d;
    logic [EW-1:0]        ent1_q, ent1_d;

    logic                 pop;
    logic                 issue;
    logic [1:0]           occ;
    logic [1:0]           cnt_after_pop;
    logic [DATA_BITS-1:0] sample_in;
    logic [EW-1:0]        new_ent;

`ifdef OFFSET_BINARY_IN_EN
    assign sample_in = bus.rd_data ^ {1'b1, {(DATA_BITS-1){1'b0}}};
`else
    assign sample_in = bus.rd_data;
`endif

    // Occupancy counts the read in flight so a stalled sink never overfills the buffer.
    assign pop           = (cnt_q != 2'd0) && bus.sink_ready;
    assign occ           = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue         = (state_q == S_RUN) && (occ < 2'd2);
    assign cnt_after_pop = cnt_q - {1'b0, pop};
    assign new_ent       = {tag_q, sample_in};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ch_d       = ch_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        inflight_d = issue;
        tag_d      = tag_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;

        if (issue) begin
            tag_d = {ch_q, addr_q == LAST_ADDR, addr_q == '0};
        end

        if (pop) begin
            ent0_d = ent1_q;
        end
        if (inflight_q) begin
            if (cnt_after_pop == 2'd0) begin
                ent0_d = new_ent;
            end else begin
                ent1_d = new_ent;
            end
        end
        cnt_d = cnt_after_pop + {1'b0, inflight_q};

        case (state_q)
            S_IDLE: begin
                // The done cycle is spent in IDLE; a start seen there belongs to the old run.
                if (start && !done_q) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_BITS'(1);
                    if (addr_q == LAST_ADDR) begin
                        if (ch_q == LAST_CH) begin
                            state_d = S_DRAIN;
                        end else begin
                            ch_d = ch_q + CH_BITS'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_d == 2'd0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            ch_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            cnt_q      <= '0;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ch_q       <= ch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign bus.rd_en      = issue;
    assign bus.rd_ch      = ch_q;
    assign bus.rd_addr    = addr_q;
    assign bus.sink_valid = (cnt_q != 2'd0);
    assign bus.sink_real  = ent0_q[DATA_BITS-1:0];
    assign bus.sink_sop   = bus.sink_valid & ent0_q[DATA_BITS];
    assign bus.sink_eop   = bus.sink_valid & ent0_q[DATA_BITS+1];
    assign bus.frame_ch   = ent0_q[EW-1 -: CH_BITS];
    assign bus.sink_imag  = '0;
    assign bus.sink_error = 2'b00;
endmodule
